irq_controller: RTL and testbench

- Interrupt request stage directly upstream of the control-register file. Collects external interrupt lines, synchronises them, latches rising edges as pending, and applies a mask plus the PSR interrupt-enable bit.
- Raises a single request to the core, which pulses the register file's `ir` input on acknowledge.
- Records the taken source in a CAUSE register readable by the trap handler.

---
 rtl/irq_controller.sv | 142 ++++++++++++++
 tb/tb_irq_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Interrupt request stage: synchronises external lines, latches rising edges as
// pending, gates them by mask and the PSR enable bit, and handshakes with the core.
`timescale 1ns/1ps
module irq_controller #(
    parameter int NUM_IRQ = 8,
    parameter int IE_BIT  = 4,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [15:0]        psr_in,
    output logic               ir_req,
    input  logic               ir_ack,
    input  logic               reg_wen,
    input  logic [1:0]         reg_addr,
    input  logic [15:0]        reg_wdata,
    output logic [15:0]        reg_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_CAUSE   = 2'd2;

    logic [NUM_IRQ-1:0] r_s1, r_s2, r_s3;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [IDX_W-1:0]   r_cause_idx;
    logic               r_cause_vld;
    state_t             r_state;

    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_active;
    logic [NUM_IRQ-1:0] w_winner_oh;
    logic [IDX_W-1:0]   w_winner;
    logic [NUM_IRQ-1:0] w_pending_nxt;
    logic               w_eligible;
    logic               w_take;
    logic               w_wr_pending;
    logic               w_wr_mask;
    logic               w_wr_cause;
    state_t             w_state_nxt;
    logic               w_unused;

    // Only the IE bit of the PSR and the low NUM_IRQ data bits are meaningful here.
    assign w_unused = ^{psr_in, reg_wdata};

    assign w_edge       = r_s2 & ~r_s3;
    assign w_active     = r_pending & r_mask;
    assign w_winner_oh  = w_active & (~w_active + NUM_IRQ'(1));
    assign w_eligible   = psr_in[IE_BIT] & (|w_active);
    assign ir_req       = (r_state == ST_REQ) & w_eligible;
    assign w_take       = ir_ack & ir_req;
    assign w_wr_pending = reg_wen & (reg_addr == ADDR_PENDING);
    assign w_wr_mask    = reg_wen & (reg_addr == ADDR_MASK);
    assign w_wr_cause   = reg_wen & (reg_addr == ADDR_CAUSE);

    always_comb begin
        w_winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) w_winner = IDX_W'(i);
        end
    end

    // An edge always wins over an ack capture or a write-1-to-clear in the same cycle.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_wr_pending) w_pending_nxt = w_pending_nxt & ~reg_wdata[NUM_IRQ-1:0];
        if (w_take)       w_pending_nxt = w_pending_nxt & ~w_winner_oh;
        w_pending_nxt = w_pending_nxt | w_edge;
    end

    // NOTE: state registers use non-blocking assignments and the asynchronous
    // reset branch so every flop clears the instant rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_s3      <= '0;
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_s1      <= irq_in;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_pending <= w_pending_nxt;
            if (w_wr_mask) r_mask <= reg_wdata[NUM_IRQ-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cause_idx <= '0;
            r_cause_vld <= 1'b0;
        end else if (w_take) begin
            r_cause_idx <= w_winner;
            r_cause_vld <= 1'b1;
        end else if (w_wr_cause) begin
            r_cause_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_eligible) w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (w_take)           w_state_nxt = ST_HOLD;
                else if (!w_eligible) w_state_nxt = ST_IDLE;
            end
            // HOLD spans the cycle in which the core clears the PSR enable bit.
            ST_HOLD: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            ADDR_PENDING: reg_rdata[NUM_IRQ-1:0] = r_pending;
            ADDR_MASK:    reg_rdata[NUM_IRQ-1:0] = r_mask;
            ADDR_CAUSE: begin
                reg_rdata[IDX_W-1:0] = r_cause_idx;
                reg_rdata[15]        = r_cause_vld;
            end
            default:      reg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of the interrupt rules.
`timescale 1ns/1ps
module tb_irq_controller;

    localparam int NUM_IRQ = 8;
    localparam int IE_BIT  = 4;
    localparam int IDX_W   = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_IRQ-1:0] irq_in;
    logic [15:0]        psr_in;
    logic               ir_req;
    logic               ir_ack;
    logic               reg_wen;
    logic [1:0]         reg_addr;
    logic [15:0]        reg_wdata;
    logic [15:0]        reg_rdata;

    irq_controller #(.NUM_IRQ(NUM_IRQ), .IE_BIT(IE_BIT), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .psr_in    (psr_in),
        .ir_req    (ir_req),
        .ir_ack    (ir_ack),
        .reg_wen   (reg_wen),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: interrupt-visible state plus the last three sampled irq_in values.
    logic [NUM_IRQ-1:0] m_pend, m_mask;
    logic [15:0]        m_cause;
    logic [NUM_IRQ-1:0] m_samp0, m_samp1, m_samp2;
    logic               m_armed;   // eligible last cycle, not acked, not in holdoff
    logic               m_holdoff; // acknowledged at the previous edge

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_cause = '0;
        m_samp0 = '0; m_samp1 = '0; m_samp2 = '0;
        m_armed = 1'b0; m_holdoff = 1'b0;
    endtask

    function automatic logic model_elig();
        return psr_in[IE_BIT] & (|(m_pend & m_mask));
    endfunction

    function automatic logic [15:0] model_rd(input logic [1:0] a);
        logic [15:0] r;
        r = '0;
        case (a)
            2'd0:    r[NUM_IRQ-1:0] = m_pend;
            2'd1:    r[NUM_IRQ-1:0] = m_mask;
            2'd2:    r = m_cause;
            default: r = '0;
        endcase
        return r;
    endfunction

    // One clock: check combinational outputs, then advance model and DUT together.
    task automatic step();
        logic [NUM_IRQ-1:0] p, act, mk;
        logic [15:0]        c;
        logic               el, rq, tk;
        int                 win;
        #1;
        el = model_elig();
        rq = m_armed & el;
        check("ir_req", 16'(ir_req), 16'(rq));
        check("rdata", reg_rdata, model_rd(reg_addr));
        tk  = ir_ack & rq;
        act = m_pend & m_mask;
        win = 0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) if (act[i]) win = i;
        p = m_pend;
        if (reg_wen && reg_addr == 2'd0) p &= ~reg_wdata[NUM_IRQ-1:0];
        if (tk) p[win] = 1'b0;
        p |= m_samp1 & ~m_samp2;
        mk = m_mask;
        if (reg_wen && reg_addr == 2'd1) mk = reg_wdata[NUM_IRQ-1:0];
        c = m_cause;
        if (tk) c = 16'h8000 | 16'(win);
        else if (reg_wen && reg_addr == 2'd2) c[15] = 1'b0;
        @(posedge clk);
        m_pend    = p;
        m_mask    = mk;
        m_cause   = c;
        m_armed   = el & ~m_holdoff & ~tk;
        m_holdoff = tk;
        m_samp2   = m_samp1;
        m_samp1   = m_samp0;
        m_samp0   = irq_in;
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        reg_wen = 1'b1; reg_addr = a; reg_wdata = d;
        step();
        reg_wen = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [15:0] e);
        reg_addr = a;
        #1;
        check(tag, reg_rdata, e);
    endtask

    task automatic req_chk(input string tag, input logic e);
        #1;
        check(tag, 16'(ir_req), 16'(e));
    endtask

    initial begin
        rst_n = 1'b0; irq_in = '0; psr_in = '0; ir_ack = 1'b0;
        reg_wen = 1'b0; reg_addr = '0; reg_wdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rd_chk("rst_pend", 2'd0, 16'h0000);
        rd_chk("rst_mask", 2'd1, 16'h0000);
        rd_chk("rst_cause", 2'd2, 16'h0000);
        req_chk("rst_req", 1'b0);
        rst_n = 1'b1;

        // Basic request
        psr_in = 16'h0010;
        wr(2'd1, 16'h0001);
        irq_in = 8'h01; step();
        irq_in = 8'h00; step();
        rd_chk("basic_pend_early", 2'd0, 16'h0000); step();
        rd_chk("basic_pend", 2'd0, 16'h0001); req_chk("basic_req_idle", 1'b0); step();
        req_chk("basic_req", 1'b1); ir_ack = 1'b1; step(); ir_ack = 1'b0;
        req_chk("basic_req_hold", 1'b0); rd_chk("basic_pend_ack", 2'd0, 16'h0000);
        rd_chk("basic_cause", 2'd2, 16'h8000); step();
        req_chk("basic_req_after", 1'b0); step();

        // Priority and masking
        wr(2'd1, 16'h00F0);
        irq_in = 8'h60; step();
        irq_in = 8'h00; step(); step(); step();
        req_chk("prio_req", 1'b1); ir_ack = 1'b1; step(); ir_ack = 1'b0;
        rd_chk("prio_cause", 2'd2, 16'h8005); rd_chk("prio_pend", 2'd0, 16'h0040);
        req_chk("prio_hold", 1'b0); step();
        req_chk("prio_idle", 1'b0); step();
        req_chk("prio_rereq", 1'b1); ir_ack = 1'b1; step(); ir_ack = 1'b0;
        rd_chk("prio_cause2", 2'd2, 16'h8006); step(); step();
        irq_in = 8'h04; step();
        irq_in = 8'h00; repeat (4) step();
        rd_chk("masked_pend", 2'd0, 16'h0004); req_chk("masked_req", 1'b0); step();
        wr(2'd0, 16'h00FF);

        // Enable gating
        psr_in = 16'h0000;
        wr(2'd1, 16'h0008);
        irq_in = 8'h08; step();
        irq_in = 8'h00; repeat (4) step();
        rd_chk("gate_pend", 2'd0, 16'h0008); req_chk("gate_req_off", 1'b0);
        psr_in = 16'h0010; req_chk("gate_req_idle", 1'b0); step();
        req_chk("gate_req_on", 1'b1); psr_in = 16'h0000; req_chk("gate_req_drop", 1'b0);
        ir_ack = 1'b1; step(); ir_ack = 1'b0;
        rd_chk("gate_cause", 2'd2, 16'h8006); rd_chk("gate_pend2", 2'd0, 16'h0008);
        psr_in = 16'h0010; req_chk("gate_idle", 1'b0); step();
        req_chk("gate_rereq", 1'b1); ir_ack = 1'b1; step(); ir_ack = 1'b0;
        rd_chk("gate_cause2", 2'd2, 16'h8003); step();

        // Simultaneous events
        psr_in = 16'h0000;
        wr(2'd1, 16'h0002);
        irq_in = 8'h02; step();
        irq_in = 8'h00; step();
        wr(2'd0, 16'h0002);
        rd_chk("sim_w1c", 2'd0, 16'h0002); step();
        wr(2'd0, 16'h0002);
        rd_chk("sim_cleared", 2'd0, 16'h0000);
        psr_in = 16'h0010;
        irq_in = 8'h02; step();
        irq_in = 8'h00; step();
        irq_in = 8'h02; step();
        irq_in = 8'h00; step();
        req_chk("sim_req", 1'b1); ir_ack = 1'b1; step(); ir_ack = 1'b0;
        rd_chk("sim_cause", 2'd2, 16'h8001); rd_chk("sim_pend", 2'd0, 16'h0002); step();
        psr_in = 16'h0000;
        wr(2'd0, 16'h0002);

        // Register access
        wr(2'd1, 16'hFFFF);
        rd_chk("reg_mask", 2'd1, 16'h00FF); step();
        wr(2'd2, 16'h1234);
        rd_chk("reg_cause", 2'd2, 16'h0001); step();
        wr(2'd3, 16'hFFFF);
        rd_chk("reg_rsvd", 2'd3, 16'h0000); rd_chk("reg_mask_kept", 2'd1, 16'h00FF); step();
        wr(2'd0, 16'hFFFF);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) irq_in = NUM_IRQ'($urandom);
            if ($urandom_range(15) == 0) begin
                psr_in = 16'($urandom);
                psr_in[IE_BIT] = ($urandom_range(3) != 0);
            end
            ir_ack    = ($urandom_range(3) == 0);
            reg_wen   = ($urandom_range(9) == 0);
            reg_addr  = 2'($urandom);
            reg_wdata = 16'($urandom);
            step();
        end

        // Asynchronous reset mid-request
        irq_in = '0; ir_ack = 1'b0; reg_wen = 1'b0; psr_in = 16'h0000;
        repeat (4) step();
        wr(2'd0, 16'hFFFF);
        wr(2'd1, 16'h0001);
        psr_in = 16'h0010;
        irq_in = 8'h01; step();
        irq_in = 8'h00; step(); step(); step();
        reg_addr = 2'd0;
        req_chk("arst_pre_req", 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_req", 16'(ir_req), 16'h0000);
        check("arst_pend", reg_rdata, 16'h0000);
        reg_addr = 2'd1; #1; check("arst_mask", reg_rdata, 16'h0000);
        reg_addr = 2'd2; #1; check("arst_cause", reg_rdata, 16'h0000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; reg_addr = 2'd0;
        repeat (4) step();
        req_chk("arst_after_req", 1'b0);
        rd_chk("arst_after_pend", 2'd0, 16'h0000);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
